// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: funct3 access codes,
// FSM state encoding, byte-enable patterns and small decode helpers.
package mau_pkg;

  // Load access codes (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store access codes (funct3)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte-enable patterns
  localparam logic [3:0] WSTRB_NONE    = 4'b0000;
  localparam logic [3:0] WSTRB_BYTE0   = 4'b0001;
  localparam logic [3:0] WSTRB_HALF_LO = 4'b0011;
  localparam logic [3:0] WSTRB_HALF_HI = 4'b1100;
  localparam logic [3:0] WSTRB_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mau_state_t;

  // Unknown funct3 codes are rejected the same way as misaligned accesses.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = off[0];
      F3_LW:         bad = |off;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte enables for a store of the size encoded in f3[1:0].
  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3[1:0])
      F3_SB[1:0]: strb = WSTRB_BYTE0 << off;
      F3_SH[1:0]: strb = off[1] ? WSTRB_HALF_HI : WSTRB_HALF_LO;
      default:    strb = WSTRB_WORD;
    endcase
    return strb;
  endfunction

  // Store data replicated into every lane so the strobes alone pick the target bytes.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] wd;
    case (f3[1:0])
      F3_SB[1:0]: wd = {4{d[7:0]}};
      F3_SH[1:0]: wd = {2{d[15:0]}};
      default:    wd = d;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Load lane selection and sign/zero extension of a returned bus word.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/halfword, then extend it according to the access type
  always_comb begin
    w_byte   = 8'h00;
    w_half   = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_result = i_rdata;
    case (i_offset)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    case (i_funct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_result = {24'h000000, w_byte};
      F3_LH:   o_result = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_result = {16'h0000, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder: one data-bus transaction per LOAD/STORE, pipeline
// stall while outstanding, misalignment and timeout reporting.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        riscv_LOAD,
  input  logic        riscv_STORE,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_toMAU,
  input  logic [31:0] data_toMAU,
  output logic [31:0] data_fromMAU,
  output logic        mau_stall,
  output logic        mau_misalign,
  output logic        mau_buserr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  // Counter only needs to reach TIMEOUT_CYCLES-1 before the abort fires.
  localparam int         CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit         TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  mau_state_t    r_state;
  mau_state_t    w_state_next;
  logic [CW-1:0] r_cnt;

  logic [31:0] r_data;
  logic        r_misalign;
  logic        r_buserr;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_wstrb;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;

  logic        w_access;
  logic        w_misaligned;
  logic        w_start;
  logic        w_timeout;
  logic        w_stall;
  logic        w_abort;
  logic [31:0] w_load_result;

  assign w_access     = riscv_LOAD | riscv_STORE;
  assign w_misaligned = is_misaligned(funct3, addr_toMAU[1:0]);
  assign w_start      = (r_state == S_IDLE) && w_access && !w_misaligned;
  assign w_timeout    = TO_EN && (r_cnt == CNT_LAST);

  mau_load_align u_load_align (
    .i_rdata  (bus_rdata),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_result (w_load_result)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, stall and abort decode; grant/rvalid take priority over a timeout
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && !w_misaligned) begin
          w_state_next = S_REQ;
          w_stall      = 1'b1;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (bus_gnt) begin
          w_state_next = r_bus_we ? S_DONE : S_WAIT;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
          w_abort      = 1'b1;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (bus_rvalid) begin
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
          w_abort      = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Timeout counter: runs while in REQ/WAIT, restarts on every state change
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Request capture, load result register and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_misalign  <= 1'b0;
      r_buserr    <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_funct3    <= '0;
      r_offset    <= '0;
    end else begin
      r_misalign <= (r_state == S_IDLE) && w_access && w_misaligned;
      r_buserr   <= w_abort;
      if (w_start) begin
        r_bus_addr  <= {addr_toMAU[31:2], 2'b00};
        r_bus_we    <= riscv_STORE;
        r_bus_wstrb <= riscv_STORE ? store_wstrb(funct3, addr_toMAU[1:0]) : WSTRB_NONE;
        r_bus_wdata <= riscv_STORE ? store_wdata(funct3, data_toMAU) : 32'h0;
        r_funct3    <= funct3;
        r_offset    <= addr_toMAU[1:0];
      end
      if (r_state == S_WAIT && bus_rvalid) begin
        r_data <= w_load_result;
      end
    end
  end

  assign data_fromMAU = r_data;
  assign mau_stall    = w_stall;
  assign mau_misalign = r_misalign;
  assign mau_buserr   = r_buserr;
  assign bus_req      = (r_state == S_REQ);
  assign bus_we       = r_bus_we;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;
  assign bus_wstrb    = r_bus_wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a small bus responder and a
// reference model computed from the load/store rules.
module tb_mem_access_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        reset;
  logic        riscv_LOAD, riscv_STORE;
  logic [2:0]  funct3;
  logic [31:0] addr_toMAU, data_toMAU;
  logic [31:0] data_fromMAU;
  logic        mau_stall, mau_misalign, mau_buserr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_data;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .riscv_LOAD(riscv_LOAD), .riscv_STORE(riscv_STORE),
    .funct3(funct3), .addr_toMAU(addr_toMAU), .data_toMAU(data_toMAU),
    .data_fromMAU(data_fromMAU), .mau_stall(mau_stall),
    .mau_misalign(mau_misalign), .mau_buserr(mau_buserr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int ref_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    longint unsigned off;
    longint unsigned sh;
    longint v;
    off = a % 4;
    sh  = longint'(w) >> (8 * off);
    case (f3)
      LB:  begin v = longint'(sh % 256);   if (v >= 128)   v = v - 256;   end
      LBU: v = longint'(sh % 256);
      LH:  begin v = longint'(sh % 65536); if (v >= 32768) v = v - 65536; end
      LHU: v = longint'(sh % 65536);
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    int m;
    nb = ref_bytes(f3);
    m  = ((1 << nb) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    int nb;
    longint unsigned part;
    longint unsigned rep;
    longint unsigned r;
    nb   = ref_bytes(f3);
    part = longint'(d) % (64'd1 << (8 * nb));
    rep  = (nb == 1) ? 64'h01010101 : (nb == 2) ? 64'h00010001 : 64'd1;
    r    = part * rep;
    return r[31:0];
  endfunction

  // ---------------- stimulus driver ----------------
  // Presents one access at the current cycle, acts as the bus target
  // (grant after gd REQ cycles, rvalid rd cycles after grant), and reports
  // what it observed. Starts and ends at 1 time unit after a rising edge.
  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int gd, input int rd,
                           input logic [31:0] rdw,
                           output logic [31:0] o_addr, output logic o_we,
                           output logic [3:0] o_wstrb, output logic [31:0] o_wdata,
                           output int o_lat, output logic [31:0] o_data, output bit o_proto);
    bit seen;
    bit granted;
    int req_cnt;
    int since;
    o_addr = '0; o_we = 1'b0; o_wstrb = '0; o_wdata = '0;
    o_lat = -1; o_data = '0; o_proto = 1'b1;
    seen = 0; granted = 0; req_cnt = 0; since = 0;
    riscv_STORE = st; riscv_LOAD = !st; funct3 = f3;
    addr_toMAU = a; data_toMAU = d; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1;
    if (!mau_stall) o_proto = 1'b0;
    for (int n = 1; n < 24; n++) begin
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (!granted) begin
        if (bus_req) begin
          if (!seen) begin
            o_addr = bus_addr; o_we = bus_we; o_wstrb = bus_wstrb; o_wdata = bus_wdata;
            seen = 1;
          end else if (o_addr !== bus_addr || o_we !== bus_we ||
                       o_wstrb !== bus_wstrb || o_wdata !== bus_wdata) begin
            o_proto = 1'b0;
          end
          if (req_cnt == gd) begin
            bus_gnt = 1'b1; granted = 1;
          end
          req_cnt++;
        end
      end else begin
        if (bus_req) o_proto = 1'b0;
        since++;
        if (!st && since == rd) begin
          bus_rvalid = 1'b1; bus_rdata = rdw;
        end
      end
      #1;
      if (mau_misalign || mau_buserr) o_proto = 1'b0;
      if (!mau_stall) begin
        o_lat  = n + 1;
        o_data = data_fromMAU;
        break;
      end
    end
    @(posedge clk); #1;
    riscv_STORE = 1'b0; riscv_LOAD = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    $display("txn %s f3=%0d addr=%08h wd=%08h gd=%0d rd=%0d lat=%0d data=%08h",
             st ? "ST" : "LD", f3, a, d, gd, rd, o_lat, o_data);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    riscv_LOAD = 0; riscv_STORE = 0; funct3 = 0; addr_toMAU = 0; data_toMAU = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({data_fromMAU, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
         mau_misalign, mau_buserr, mau_stall} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%08h req=%b we=%b addr=%08h wd=%08h strb=%b mis=%b err=%b stall=%b, want all zero",
               data_fromMAU, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, mau_misalign, mau_buserr, mau_stall);
    end
    reset = 1'b0;
    exp_data = '0;
  endtask

  task automatic test_store_word;
    logic [31:0] oa, ow, od; logic owe; logic [3:0] os; int ol; bit op;
    do_access(1'b1, SW, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0, oa, owe, os, ow, ol, od, op);
    n_cmp++; if (oa !== 32'h100)      begin n_bad++; $display("FAIL sw_addr: got %08h want 00000100", oa); end
    n_cmp++; if (owe !== 1'b1)        begin n_bad++; $display("FAIL sw_we: got %b want 1", owe); end
    n_cmp++; if (os !== 4'b1111)      begin n_bad++; $display("FAIL sw_wstrb: got %b want 1111", os); end
    n_cmp++; if (ow !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata: got %08h want deadbeef", ow); end
    n_cmp++; if (ol !== 3)            begin n_bad++; $display("FAIL sw_latency: got %0d want 3", ol); end
    n_cmp++; if (!op)                 begin n_bad++; $display("FAIL sw_protocol: got 0 want 1"); end
  endtask

  task automatic test_store_lanes;
    logic [2:0]  f3s [2] = '{SB, SH};
    logic [31:0] as  [2] = '{32'h103, 32'h102};
    logic [31:0] ds  [2] = '{32'h000000A5, 32'h00001234};
    logic [3:0]  es  [2] = '{4'b1000, 4'b1100};
    logic [31:0] ew  [2] = '{32'hA5A5A5A5, 32'h12341234};
    logic [31:0] oa, ow, od; logic owe; logic [3:0] os; int ol; bit op;
    for (int i = 0; i < 2; i++) begin
      do_access(1'b1, f3s[i], as[i], ds[i], 1, 1, 32'h0, oa, owe, os, ow, ol, od, op);
      n_cmp++; if (os !== es[i]) begin n_bad++; $display("FAIL lane_wstrb[%0d]: got %b want %b", i, os, es[i]); end
      n_cmp++; if (ow !== ew[i]) begin n_bad++; $display("FAIL lane_wdata[%0d]: got %08h want %08h", i, ow, ew[i]); end
      n_cmp++; if (oa !== 32'h100) begin n_bad++; $display("FAIL lane_addr[%0d]: got %08h want 00000100", i, oa); end
      n_cmp++; if (ol !== 4) begin n_bad++; $display("FAIL lane_latency[%0d]: got %0d want 4", i, ol); end
      n_cmp++; if (od !== exp_data) begin n_bad++; $display("FAIL lane_data_hold[%0d]: got %08h want %08h", i, od, exp_data); end
    end
  endtask

  task automatic test_load_extend;
    logic [2:0]  f3s [5] = '{LB, LBU, LH, LHU, LW};
    logic [31:0] as  [5] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h200};
    logic [31:0] es  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F01, 32'h80F17F01};
    logic [31:0] oa, ow, od; logic owe; logic [3:0] os; int ol; bit op;
    for (int i = 0; i < 5; i++) begin
      do_access(1'b0, f3s[i], as[i], 32'hFFFFFFFF, 0, 1, 32'h80F17F01, oa, owe, os, ow, ol, od, op);
      exp_data = es[i];
      n_cmp++; if (od !== es[i]) begin n_bad++; $display("FAIL load_ext[%0d]: got %08h want %08h", i, od, es[i]); end
      n_cmp++; if (oa !== 32'h200 || owe !== 1'b0 || os !== 4'b0000 || ow !== 32'h0) begin
        n_bad++; $display("FAIL load_bus[%0d]: got addr=%08h we=%b strb=%b wd=%08h want 00000200/0/0000/0", i, oa, owe, os, ow);
      end
      n_cmp++; if (ol !== 4) begin n_bad++; $display("FAIL load_latency[%0d]: got %0d want 4", i, ol); end
    end
  endtask

  task automatic test_misalign;
    bit          sts [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [3] = '{LW, SH, 3'b011};
    logic [31:0] as  [3] = '{32'h201, 32'h101, 32'h200};
    for (int i = 0; i < 3; i++) begin
      riscv_LOAD = !sts[i]; riscv_STORE = sts[i]; funct3 = f3s[i];
      addr_toMAU = as[i]; data_toMAU = $urandom;
      #1;
      n_cmp++; if (mau_stall !== 1'b0) begin n_bad++; $display("FAIL mis_stall[%0d]: got %b want 0", i, mau_stall); end
      @(posedge clk); #1;
      riscv_LOAD = 1'b0; riscv_STORE = 1'b0;
      n_cmp++; if (mau_misalign !== 1'b1 || bus_req !== 1'b0) begin
        n_bad++; $display("FAIL mis_pulse[%0d]: got mis=%b req=%b want 1/0", i, mau_misalign, bus_req);
      end
      @(posedge clk); #1;
      n_cmp++; if (mau_misalign !== 1'b0 || bus_req !== 1'b0 || data_fromMAU !== exp_data) begin
        n_bad++; $display("FAIL mis_after[%0d]: got mis=%b req=%b data=%08h want 0/0/%08h", i, mau_misalign, bus_req, data_fromMAU, exp_data);
      end
      $display("txn MIS f3=%0d addr=%08h", f3s[i], as[i]);
    end
  endtask

  task automatic test_timeout;
    int req_cnt = 0;
    int err_cnt = 0;
    int err_cyc = -1;
    logic err_stall = 1'b1;
    logic [31:0] oa, ow, od; logic owe; logic [3:0] os; int ol; bit op;
    riscv_STORE = 1'b1; riscv_LOAD = 1'b0; funct3 = SW; addr_toMAU = 32'h400; data_toMAU = 32'h5555AAAA;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 6) riscv_STORE = 1'b0;
      if (bus_req) req_cnt++;
      if (mau_buserr) begin err_cnt++; err_cyc = c; err_stall = mau_stall; end
    end
    $display("txn TMO addr=00000400 req_cycles=%0d buserr_at=%0d", req_cnt, err_cyc);
    n_cmp++; if (req_cnt !== 4) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d want 4", req_cnt); end
    n_cmp++; if (err_cnt !== 1 || err_cyc !== 5) begin
      n_bad++; $display("FAIL timeout_buserr: got count=%0d cycle=%0d want 1 at 5", err_cnt, err_cyc);
    end
    n_cmp++; if (err_stall !== 1'b0) begin n_bad++; $display("FAIL timeout_done_stall: got %b want 0", err_stall); end
    n_cmp++; if (data_fromMAU !== exp_data) begin n_bad++; $display("FAIL timeout_data_hold: got %08h want %08h", data_fromMAU, exp_data); end
    do_access(1'b1, SW, 32'h404, 32'h0BADCAFE, 0, 1, 32'h0, oa, owe, os, ow, ol, od, op);
    n_cmp++; if (ol !== 3 || ow !== 32'h0BADCAFE || oa !== 32'h404 || !op) begin
      n_bad++; $display("FAIL timeout_recover: got lat=%0d wd=%08h addr=%08h proto=%0d want 3/0badcafe/00000404/1", ol, ow, oa, op);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] oa, ow, od; logic owe; logic [3:0] os; int ol; bit op;
    do_access(1'b0, LW, 32'h500, 32'h0, 0, 1, 32'hCAFEF00D, oa, owe, os, ow, ol, od, op);
    exp_data = 32'hCAFEF00D;
    n_cmp++; if (od !== exp_data) begin n_bad++; $display("FAIL rmid_preload: got %08h want cafef00d", od); end
    riscv_LOAD = 1'b1; funct3 = LW; addr_toMAU = 32'h504;
    @(posedge clk); #1;                       // REQ
    bus_gnt = 1'b1;
    @(posedge clk); #1;                       // WAIT
    bus_gnt = 1'b0; reset = 1'b1;
    @(posedge clk); #1;                       // reset taken
    reset = 1'b0; riscv_LOAD = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    exp_data = 32'h0;
    #1;
    n_cmp++; if (bus_req !== 1'b0 || data_fromMAU !== 32'h0 || mau_stall !== 1'b0) begin
      n_bad++; $display("FAIL rmid_abort: got req=%b data=%08h stall=%b want 0/0/0", bus_req, data_fromMAU, mau_stall);
    end
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    n_cmp++; if (bus_req !== 1'b0 || data_fromMAU !== 32'h0 || mau_stall !== 1'b0) begin
      n_bad++; $display("FAIL rmid_late_rvalid: got req=%b data=%08h stall=%b want 0/0/0", bus_req, data_fromMAU, mau_stall);
    end
    $display("txn RST mid-WAIT addr=00000504");
  endtask

  task automatic test_back_to_back_random;
    logic [2:0]  ld_ops [5] = '{LB, LH, LW, LBU, LHU};
    logic [2:0]  st_ops [3] = '{SB, SH, SW};
    logic [31:0] oa, ow, od; logic owe; logic [3:0] os; int ol; bit op;
    for (int i = 0; i < 40; i++) begin
      bit st;
      logic [2:0]  f3;
      logic [31:0] a, d, rw, e_addr, e_wd;
      logic [3:0]  e_strb;
      int gd, rd, e_lat, nb;
      st = 1'($urandom_range(0, 1));
      f3 = st ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
      nb = ref_bytes(f3);
      a  = $urandom & ~(32'(nb) - 32'd1);
      d  = $urandom; rw = $urandom;
      gd = $urandom_range(0, 3); rd = $urandom_range(1, 3);
      do_access(st, f3, a, d, gd, rd, rw, oa, owe, os, ow, ol, od, op);
      e_addr = a & 32'hFFFFFFFC;
      e_strb = st ? ref_wstrb(f3, a) : 4'b0000;
      e_wd   = st ? ref_wdata(f3, d) : 32'h0;
      e_lat  = 3 + gd + (st ? 0 : rd);
      if (!st) exp_data = ref_load(f3, a, rw);
      n_cmp++; if (oa !== e_addr || owe !== st) begin
        n_bad++; $display("FAIL rnd_addr_we[%0d]: got %08h/%b want %08h/%b", i, oa, owe, e_addr, st);
      end
      n_cmp++; if (os !== e_strb || ow !== e_wd) begin
        n_bad++; $display("FAIL rnd_lanes[%0d]: got %b/%08h want %b/%08h", i, os, ow, e_strb, e_wd);
      end
      n_cmp++; if (ol !== e_lat) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, ol, e_lat); end
      n_cmp++; if (od !== exp_data) begin n_bad++; $display("FAIL rnd_data[%0d]: got %08h want %08h", i, od, exp_data); end
      n_cmp++; if (!op) begin n_bad++; $display("FAIL rnd_protocol[%0d]: got 0 want 1", i); end
    end
  endtask

  initial begin
    test_reset;
    test_store_word;
    test_store_lanes;
    test_load_extend;
    test_misalign;
    test_timeout;
    test_reset_mid;
    test_back_to_back_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
